// File: rtl/edge_train_pkg.sv
// rtl/edge_train_pkg.sv - shared types and width helpers for the edge train generator
// Purpose: state encoding for the pulse FSM plus constant-width helpers used to
//          size the pending-request counter and the cycle timer.
// Contents:
//   edge_train_state_t  IDLE / HIGH / GAP
//   safe_width(v)       bits needed to hold 0..v, never less than 1
//   max2(a, b)          larger of two ints
package edge_train_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } edge_train_state_t;

  // A plain $clog2 collapses to 0 for a range of 0..1 or 0..0; a zero-width
  // vector is illegal, so clamp to at least one bit.
  function automatic int safe_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gen_cycle_timer.sv
// rtl/gen_cycle_timer.sv - loadable down-counter with zero flag
// Purpose: counts down from a loaded value and parks at zero.
// Ports:
//   clk         in   clock, rising edge
//   n_rst       in   synchronous active-low reset (count -> 0)
//   load_i      in   load load_val_i this edge (wins over decrement)
//   load_val_i  in   value to load
//   zero_o      out  count is zero
module gen_cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/edge_train_gen.sv
// rtl/edge_train_gen.sv - turns request strobes into distinct, gap-separated level pulses
// Purpose: each accepted request produces one pulse on sig, high for HIGH_CYCLES
//          and followed by at least GAP_CYCLES low, so a downstream positive-edge
//          detector sees exactly one rising edge per request. Requests arriving
//          while a pulse is in flight are queued in a saturating counter.
// Optional feature: EDGE_TRAIN_OVF_FLAG_EN enables the sticky overflow flag and
//          clr_ovf; without it overflow is tied 0 and drops are silent.
// Ports:
//   clk          in   clock, rising edge
//   n_rst        in   synchronous active-low reset
//   strobe       in   one request per cycle high
//   clr_ovf      in   clears sticky overflow (feature build only)
//   sig          out  registered level pulse
//   busy         out  FSM not idle
//   pending_cnt  out  queued requests not yet started
//   overflow     out  sticky request-dropped flag
module edge_train_gen
  import edge_train_pkg::*;
#(
  parameter int HIGH_CYCLES = 3,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PENDING = 4,
  localparam int PW = safe_width(MAX_PENDING)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          strobe,
  input  logic          clr_ovf,
  output logic          sig,
  output logic          busy,
  output logic [PW-1:0] pending_cnt,
  output logic          overflow
);

  localparam int TW = safe_width(max2(HIGH_CYCLES, GAP_CYCLES) - 1);
  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  edge_train_state_t state_q, state_d;
  logic          sig_q, busy_q;
  logic [PW-1:0] pend_q, pend_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  logic          start;
  logic          from_queue;
  logic          strobe_enq;
  logic          drop;

  gen_cycle_timer #(
    .W(TW)
  ) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_val    = HIGH_LOAD;
    start      = 1'b0;
    from_queue = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = HIGH_LOAD;
          start    = 1'b1;
        end
      end
      HIGH: begin
        if (tmr_zero) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          if ((pend_q != '0) || strobe) begin
            state_d    = HIGH;
            tmr_load   = 1'b1;
            tmr_val    = HIGH_LOAD;
            start      = 1'b1;
            // Queued requests are older, so they go first; a same-cycle
            // strobe then simply takes the freed queue slot.
            from_queue = (pend_q != '0);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A strobe is consumed only by a start that did not come from the queue.
  assign strobe_enq = strobe && !(start && !from_queue);
  // When a queued start happens the decrement guarantees room, so no drop.
  assign drop       = strobe_enq && !from_queue && (pend_q == PEND_MAX);

  always_comb begin
    pend_d = pend_q;
    if (from_queue && !strobe_enq) begin
      pend_d = pend_q - 1'b1;
    end else if (!from_queue && strobe_enq && (pend_q != PEND_MAX)) begin
      pend_d = pend_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
      pend_q  <= pend_d;
    end
  end

  assign sig         = sig_q;
  assign busy        = busy_q;
  assign pending_cnt = pend_q;

`ifdef EDGE_TRAIN_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // Setting beats clearing so a drop coincident with clr_ovf is never lost.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = clr_ovf ^ drop;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_edge_train_gen.sv
// tb/tb_edge_train_gen.sv - directed self-checking bench for edge_train_gen
module tb_edge_train_gen;

  logic       clk;
  logic       n_rst;
  logic       strobe;
  logic       clr_ovf;
  logic       sig;
  logic       busy;
  logic [2:0] pending_cnt;
  logic       overflow;

  int chk_cnt;
  int err_cnt;
  int rise_cnt;
  logic sig_prev;

`ifdef EDGE_TRAIN_OVF_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  edge_train_gen #(
    .HIGH_CYCLES(3),
    .GAP_CYCLES (2),
    .MAX_PENDING(4)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .strobe     (strobe),
    .clr_ovf    (clr_ovf),
    .sig        (sig),
    .busy       (busy),
    .pending_cnt(pending_cnt),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs set before a tick are sampled by that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sig && !sig_prev) rise_cnt++;
    sig_prev = sig;
  endtask

  // 16 edges; bit/nibble order is time order (leftmost = first edge).
  task automatic run_seq(input string name, input logic [15:0] stb, input logic [15:0] exp_sig,
                         input logic [15:0] exp_busy, input logic [63:0] exp_pend);
    for (int i = 0; i < 16; i++) begin
      strobe = stb[15-i];
      tick();
      check($sformatf("%s_sig_e%0d", name, i), 32'(sig), 32'(exp_sig[15-i]));
      check($sformatf("%s_busy_e%0d", name, i), 32'(busy), 32'(exp_busy[15-i]));
      check($sformatf("%s_pend_e%0d", name, i), 32'(pending_cnt), 32'(exp_pend[(15-i)*4 +: 4]));
    end
    strobe = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [15:0] s1_sig;
    logic [15:0] s1_busy;
    chk_cnt  = 0;
    err_cnt  = 0;
    rise_cnt = 0;
    sig_prev = 1'b0;
    n_rst    = 1'b0;
    strobe   = 1'b0;
    clr_ovf  = 1'b0;
    tick();
    tick();
    check("rst_sig", 32'(sig), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pend", 32'(pending_cnt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    n_rst = 1'b1;
    idle_ticks(3);

    // 1) single strobe: high for 3 edges, low 2, idle at the 6th
    s1_sig  = 16'b1110_0000_0000_0000;
    s1_busy = 16'b1111_1000_0000_0000;
    run_seq("single", 16'b1000_0000_0000_0000, s1_sig, s1_busy, 64'h0000_0000_0000_0000);
    check("single_rises", 32'(rise_cnt), 32'd1);

    // 2) three back-to-back strobes -> pulses at t, t+5, t+10
    rise_cnt = 0;
    run_seq("burst3", 16'b1110_0000_0000_0000, 16'b1110_0111_0011_1000,
            16'b1111_1111_1111_1110, 64'h0122_2111_1100_0000);
    check("burst3_rises", 32'(rise_cnt), 32'd3);

    // 4) strobe on the final gap edge with pending=2 -> immediate start, pending stays 2
    rise_cnt = 0;
    run_seq("gapstb", 16'b1110_0100_0000_0000, 16'b1110_0111_0011_1001,
            16'b1111_1111_1111_1111, 64'h0122_2222_2211_1110);
    idle_ticks(5);
    check("gapstb_idle", 32'(busy), 32'd0);
    check("gapstb_rises", 32'(rise_cnt), 32'd4);

    // 3) strobe held 7 edges: queue saturates at 4, the strobe on edge 6 is dropped
    rise_cnt = 0;
    run_seq("hold7", 16'b1111_1110_0000_0000, 16'b1110_0111_0011_1001,
            16'b1111_1111_1111_1111, 64'h0123_4444_4433_3332);
    check("hold7_ovf", 32'(overflow), 32'(OVF_EN));
    idle_ticks(15);
    check("hold7_idle", 32'(busy), 32'd0);
    check("hold7_rises", 32'(rise_cnt), 32'd6);
    check("hold7_ovf_sticky", 32'(overflow), 32'(OVF_EN));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("hold7_ovf_clr", 32'(overflow), 32'd0);

    // 6) drop coincident with clr_ovf keeps the flag; clr_ovf alone clears it
    strobe = 1'b1;
    idle_ticks(7);
    check("clrset_pend_full", 32'(pending_cnt), 32'd4);
    check("clrset_ovf_set", 32'(overflow), 32'(OVF_EN));
    clr_ovf = 1'b1;
    tick();
    check("clrset_ovf_hold", 32'(overflow), 32'(OVF_EN));
    strobe = 1'b0;
    tick();
    clr_ovf = 1'b0;
    check("clrset_ovf_clr", 32'(overflow), 32'd0);
    idle_ticks(30);
    check("clrset_idle", 32'(busy), 32'd0);

    // 5) reset on the 2nd high edge of a queued pulse with pending=3
    strobe = 1'b1;
    idle_ticks(5);
    strobe = 1'b0;
    tick();
    check("midrst_pre_pend", 32'(pending_cnt), 32'd3);
    check("midrst_pre_sig", 32'(sig), 32'd1);
    n_rst = 1'b0;
    tick();
    check("midrst_sig", 32'(sig), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pend", 32'(pending_cnt), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    n_rst    = 1'b1;
    rise_cnt = 0;
    idle_ticks(20);
    check("midrst_no_pulses", 32'(rise_cnt), 32'd0);
    check("midrst_still_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
